// File: rtl/cpu_test_sequencer.sv
// Drives one self-checking test program on the rv32is core: holds the core in reset,
// runs it until the end-of-test magic word or a cycle limit, then grades the result register.
module cpu_test_sequencer #(
   parameter int          MAXCYCLES  = 10000,
   parameter int          CNT_W      = 16,
   parameter int          RST_CYCLES = 1,
   parameter logic [31:0] MAGIC_END  = 32'hdead10cc,
   parameter logic [31:0] PASS_VAL   = 32'h00c0ffee,
   parameter logic [31:0] FAIL_VAL   = 32'hdeaddead,
   parameter logic [4:0]  RESULT_REG = 5'd10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      imem_data,
   input  logic [31:0]      dbg_regdata,
   output logic             cpu_reset,
   output logic [4:0]       dbg_regsel,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic [CNT_W-1:0] cycles
);

   localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES);
   localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAXCYCLES - 1);
   localparam logic [CNT_W-1:0]  CYC_MAX   = CNT_W'(MAXCYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_HOLD, S_RUN, S_SEL, S_SAMPLE, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      ST_PASS = 2'd0, ST_FAIL = 2'd1, ST_UNKNOWN = 2'd2, ST_TIMEOUT = 2'd3
   } status_t;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              cpu_reset_d, busy_d, done_d;
   logic [4:0]        regsel_d;
   logic [1:0]        status_d;
   logic [CNT_W-1:0]  cycles_d;
   logic              in_run;

   assign in_run = (state_q == S_HOLD) || (state_q == S_RUN) ||
                   (state_q == S_SEL)  || (state_q == S_SAMPLE);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
      state_d     = state_q;
      hold_d      = hold_q;
      cpu_reset_d = cpu_reset;
      regsel_d    = dbg_regsel;
      busy_d      = busy;
      done_d      = done;
      status_d    = status;
      cycles_d    = cycles;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && !abort) begin
               state_d     = S_HOLD;
               hold_d      = HOLD_INIT;
               cpu_reset_d = 1'b1;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               status_d    = ST_PASS;
               cycles_d    = '0;
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_W'(1)) begin
               state_d     = S_RUN;
               cpu_reset_d = 1'b0;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         S_RUN: begin
            // The magic word wins over the timeout when both land on the same cycle.
            if (imem_data == MAGIC_END) begin
               state_d     = S_SEL;
               regsel_d    = RESULT_REG;
               cpu_reset_d = 1'b1;
            end else if (cycles == CYC_LAST) begin
               state_d     = S_DONE;
               status_d    = ST_TIMEOUT;
               cycles_d    = CYC_MAX;
               cpu_reset_d = 1'b1;
               busy_d      = 1'b0;
               done_d      = 1'b1;
            end else begin
               cycles_d = cycles + CNT_W'(1);
            end
         end
         S_SEL: begin
            // Core is frozen; the debug read of the result register settles during this cycle.
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (dbg_regdata == PASS_VAL)      status_d = ST_PASS;
            else if (dbg_regdata == FAIL_VAL) status_d = ST_FAIL;
            else                              status_d = ST_UNKNOWN;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && in_run) begin
         state_d     = S_IDLE;
         hold_d      = hold_q;
         cpu_reset_d = 1'b1;
         busy_d      = 1'b0;
         done_d      = 1'b0;
         status_d    = status;
         cycles_d    = cycles;
         regsel_d    = dbg_regsel;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         hold_q     <= '0;
         cpu_reset  <= 1'b1;
         dbg_regsel <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         status     <= ST_PASS;
         cycles     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         hold_q     <= hold_d;
         cpu_reset  <= cpu_reset_d;
         dbg_regsel <= regsel_d;
         busy       <= busy_d;
         done       <= done_d;
         status     <= status_d;
         cycles     <= cycles_d;
      end
   end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer: a table of complete test runs plus hand-written
// sequences for abort, start-while-busy and asynchronous reset mid-run.
module tb_cpu_test_sequencer;

   localparam int          MAXC   = 20;
   localparam logic [31:0] MAGIC  = 32'hdead10cc;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] imem_data = NOP;
   logic [31:0] dbg_regdata = '0;
   logic        cpu_reset;
   logic [4:0]  dbg_regsel;
   logic        busy;
   logic        done;
   logic [1:0]  status;
   logic [15:0] cycles;

   int n_checks = 0;
   int n_fail   = 0;

   cpu_test_sequencer #(
      .MAXCYCLES (MAXC),
      .CNT_W     (16),
      .RST_CYCLES(1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .imem_data  (imem_data),
      .dbg_regdata(dbg_regdata),
      .cpu_reset  (cpu_reset),
      .dbg_regsel (dbg_regsel),
      .busy       (busy),
      .done       (done),
      .status     (status),
      .cycles     (cycles)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      int          magic_at;     // RUN cycle carrying the magic word, 0 = never
      logic [31:0] regdata;
      logic [1:0]  exp_status;
      int          exp_cycles;
      logic [4:0]  exp_regsel;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 64; i++) begin
         if (done === 1'b1) break;
         @(negedge clock);
      end
      check({name, " done reached"}, 32'(done), 32'd1);
   endtask

   // Starts a run at a negedge and drives imem_data so the magic word appears on RUN cycle magic_at.
   task automatic do_run(input string name, input int magic_at, input logic [31:0] regdata);
      dbg_regdata = regdata;
      imem_data   = NOP;
      start       = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({name, " hold cpu_reset"}, 32'(cpu_reset), 32'd1);
      check({name, " hold busy"}, 32'(busy), 32'd1);
      check({name, " hold done"}, 32'(done), 32'd0);
      check({name, " hold cycles"}, 32'(cycles), 32'd0);
      @(negedge clock);
      check({name, " run cpu_reset"}, 32'(cpu_reset), 32'd0);
      for (int k = 1; k <= magic_at; k++) begin
         imem_data = (k == magic_at) ? MAGIC : NOP + 32'(k);
         @(negedge clock);
      end
      imem_data = NOP;
      if (magic_at > 0) begin
         check({name, " sel cpu_reset"}, 32'(cpu_reset), 32'd1);
         check({name, " sel regsel"}, 32'(dbg_regsel), 32'd10);
         check({name, " sel busy"}, 32'(busy), 32'd1);
      end
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"timeout",         0, 32'h00c0ffee, 2'd3, 20, 5'd0};
      vecs[1] = '{"pass",            5, 32'h00c0ffee, 2'd0, 4,  5'd10};
      vecs[2] = '{"fail",            5, 32'hdeaddead, 2'd1, 4,  5'd10};
      vecs[3] = '{"unknown",         5, 32'h12345678, 2'd2, 4,  5'd10};
      vecs[4] = '{"magic_at_limit", 20, 32'h00c0ffee, 2'd0, 19, 5'd10};
      vecs[5] = '{"limit_unknown",  20, 32'h12345678, 2'd2, 19, 5'd10};
      vecs[6] = '{"magic_first",     1, 32'hdeaddead, 2'd1, 0,  5'd10};

      // Reset state.
      #12;
      check("rst cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst regsel", 32'(dbg_regsel), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst status", 32'(status), 32'd0);
      check("rst cycles", 32'(cycles), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) begin
         do_run(vecs[i].name, vecs[i].magic_at, vecs[i].regdata);
         check({vecs[i].name, " busy"}, 32'(busy), 32'd0);
         check({vecs[i].name, " status"}, 32'(status), 32'(vecs[i].exp_status));
         check({vecs[i].name, " cycles"}, 32'(cycles), 32'(vecs[i].exp_cycles));
         check({vecs[i].name, " cpu_reset"}, 32'(cpu_reset), 32'd1);
         check({vecs[i].name, " regsel"}, 32'(dbg_regsel), 32'(vecs[i].exp_regsel));
         @(negedge clock);
         check({vecs[i].name, " status hold"}, 32'(status), 32'(vecs[i].exp_status));
      end

      // abort and start together in DONE: abort has no effect, start is dropped.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      check("done_abort_start busy", 32'(busy), 32'd0);
      check("done_abort_start done", 32'(done), 32'd1);
      check("done_abort_start status", 32'(status), 32'd1);
      @(negedge clock);
      check("done_abort_start idle busy", 32'(busy), 32'd0);

      // Abort once three RUN cycles have been counted.
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (cycles == 16'd3) break;
         @(negedge clock);
      end
      check("abort pre cycles", 32'(cycles), 32'd3);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort cpu_reset", 32'(cpu_reset), 32'd1);
      check("abort cycles", 32'(cycles), 32'd3);
      repeat (3) @(negedge clock);
      check("abort idle cycles", 32'(cycles), 32'd3);
      check("abort idle busy", 32'(busy), 32'd0);

      // A fresh run after abort starts from zero.
      do_run("after_abort", 3, 32'h00c0ffee);
      check("after_abort status", 32'(status), 32'd0);
      check("after_abort cycles", 32'(cycles), 32'd2);

      // start held high while busy, then asynchronous reset between edges.
      start = 1'b1;
      repeat (2) @(negedge clock);
      repeat (5) @(negedge clock);
      check("start_held cycles", 32'(cycles), 32'd5);
      check("start_held cpu_reset", 32'(cpu_reset), 32'd0);
      check("start_held busy", 32'(busy), 32'd1);
      start = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_rst cpu_reset", 32'(cpu_reset), 32'd1);
      check("async_rst busy", 32'(busy), 32'd0);
      check("async_rst done", 32'(done), 32'd0);
      check("async_rst cycles", 32'(cycles), 32'd0);
      check("async_rst status", 32'(status), 32'd0);
      check("async_rst regsel", 32'(dbg_regsel), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("post_rst busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_test_sequencer.md
Name: cpu_test_sequencer

Overview:
Hardware sequencer that runs one self-checking RISC-V test program on the rv32is core without a testbench in the loop. On start it holds the CPU in reset, releases it, and counts cycles until the fetched instruction equals the end-of-test magic word or a cycle limit expires. It then reads the result register through the register-file debug read port and reports pass, fail, unknown or timeout. It sits beside the core and drives the core's reset and debug register select; instruction and data memory preloading stay outside this block.

Parameters:
MAXCYCLES, 10000, run-cycle limit before timeout
CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > MAXCYCLES
RST_CYCLES, 1, cycles the CPU is held in reset after start (>=1)
MAGIC_END, 32'hdead10cc, end-of-test instruction word
PASS_VAL, 32'h00c0ffee, result value meaning pass
FAIL_VAL, 32'hdeaddead, result value meaning fail
RESULT_REG, 10, register index checked (a0)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: begin a test run (sampled in IDLE/DONE only)
abort  in  1  level: cancel the current run
imem_data  in  32  instruction word currently fetched by the core (imemdataout)
dbg_regdata  in  32  register-file debug read data, valid 1 cycle after dbg_regsel changes
cpu_reset  out  1  active-high reset to the core
dbg_regsel  out  5  register-file debug read index
busy  out  1  run in progress
done  out  1  result valid
status  out  2  0=pass 1=fail 2=unknown 3=timeout
cycles  out  CNT_W  run cycles counted in the last/current run

Behaviour:
- Async reset (reset=0): state IDLE; cpu_reset=1, dbg_regsel=0, busy=0, done=0, status=0, cycles=0.
- States: IDLE, HOLD, RUN, SEL, SAMPLE, DONE. All outputs are registered.
- IDLE/DONE + start=1: next state HOLD; cpu_reset=1, busy=1, done=0, status=0, cycles=0, hold counter loaded with RST_CYCLES.
- HOLD: hold counter decrements each cycle. When it reaches 1, the next state is RUN and cpu_reset=0 in the same edge. The core is therefore in reset for exactly RST_CYCLES cycles.
- RUN: each cycle, evaluated in priority order:
  (a) imem_data==MAGIC_END -> SEL; cycles not incremented;
  (b) cycles==MAXCYCLES-1 -> DONE, status=3, cycles=MAXCYCLES, cpu_reset=1;
  (c) otherwise cycles+1.
  Magic takes precedence over timeout in the same cycle. cycles never exceeds MAXCYCLES.
- SEL: dbg_regsel=RESULT_REG, cpu_reset=1 (core frozen; the register file is still readable). Next state is SAMPLE.
- SAMPLE: compare dbg_regdata. PASS_VAL -> status=0; FAIL_VAL -> status=1; anything else -> status=2. Next state is DONE.
- DONE: done=1, busy=0, cpu_reset=1. status and cycles hold until the next start.
- start while busy=1 is ignored.
- abort=1 in HOLD/RUN/SEL/SAMPLE: next state IDLE; cpu_reset=1, busy=0, done=0; cycles keeps the partial count. abort in IDLE/DONE has no effect. abort and start both high in IDLE/DONE: abort wins and start is dropped.
- Reset asserted mid-run returns the block to the reset values immediately, regardless of state.

Test Plan:
- start with imem_data=MAGIC_END appearing on the 5th RUN cycle, dbg_regdata=32'h00c0ffee -> cpu_reset high 1 cycle then low; done=1, status=0, cycles=4, dbg_regsel=10.
- Same run with dbg_regdata=32'hdeaddead -> status=1; with 32'h12345678 -> status=2.
- imem_data never equals MAGIC_END, MAXCYCLES=20 -> done=1, status=3, cycles=20, cpu_reset=1, dbg_regsel never set.
- MAGIC_END on the same cycle cycles==MAXCYCLES-1 -> SEL path taken, status from dbg_regdata, not 3.
- abort raised on RUN cycle 3 -> busy=0, done=0, cpu_reset=1, cycles=3; a following start runs a fresh test from cycles=0.
- reset driven low during RUN, asynchronously between edges -> all outputs return to reset values immediately; start held high during busy -> no restart observed.
